// File: rtl/conv2d_pkg.sv
// Shared types and elaboration-time helpers for the Conv2D sequencing controller.
package conv2d_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic int calc_ow(input int w, input int ks, input int s);
    return (w - ks) / s + 1;
  endfunction

  function automatic int calc_oh(input int h, input int ks, input int s);
    return (h - ks) / s + 1;
  endfunction

  function automatic int window_stride(input int ks);
    return ks * ks;
  endfunction

  function automatic int plane_stride(input int h, input int w);
    return h * w;
  endfunction

  function automatic int calc_mac_len(input int ks, input int c);
    return window_stride(ks) * c;
  endfunction

  function automatic int calc_groups(input int k, input int l);
    return k / l;
  endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// Wrapping 0..LIMIT-1 loop counter; wrap flags the last value so counters chain.
module conv_loop_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output logic wrap
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  assign wrap = (count == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (inc) count <= wrap ? '0 : count + CW'(1);
  end
endmodule

// File: rtl/conv2d_scheduler.sv
// Layer sequencer for the Conv2D engine: clear/MAC/drain/write framing per pixel
// and kernel group, with all addresses stepped incrementally by constant adders.
module conv2d_scheduler
  import conv2d_pkg::*;
#(
  parameter int KERNEL_SIZE                = 3,
  parameter int KERNELS                    = 4,
  parameter int LANES                      = 4,
  parameter int STRIDE                     = 1,
  parameter int INPUT_WIDTH                = 5,
  parameter int INPUT_HEIGHT               = 5,
  parameter int CHANNELS                   = 3,
  parameter int ENGINE_LATENCY             = 1,
  parameter int WEIGHT_BUFFER_ADDRESS_BITS = 8,
  parameter int INPUT_BUFFER_ADDRESS_BITS  = 8,
  parameter int OUTPUT_BUFFER_ADDRESS_BITS = 7
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          clear,
  output logic                                          valid,
  output logic [INPUT_BUFFER_ADDRESS_BITS-1:0]          x_address,
  output logic [LANES*WEIGHT_BUFFER_ADDRESS_BITS-1:0]   w_address,
  output logic [LANES*OUTPUT_BUFFER_ADDRESS_BITS-1:0]   out_address,
  output logic                                          write
);
  localparam int WB      = WEIGHT_BUFFER_ADDRESS_BITS;
  localparam int IB      = INPUT_BUFFER_ADDRESS_BITS;
  localparam int OB      = OUTPUT_BUFFER_ADDRESS_BITS;
  localparam int KS      = KERNEL_SIZE;
  localparam int OW      = calc_ow(INPUT_WIDTH, KS, STRIDE);
  localparam int OH      = calc_oh(INPUT_HEIGHT, KS, STRIDE);
  localparam int OHOW    = OW * OH;
  localparam int MAC_LEN = calc_mac_len(KS, CHANNELS);
  localparam int GROUPS  = calc_groups(KERNELS, LANES);
  localparam int DW      = (ENGINE_LATENCY > 1) ? $clog2(ENGINE_LATENCY) : 1;

  // Jumps applied when the kx / ky / c and ox / oy loops roll over.
  localparam logic [IB-1:0] X_KX = IB'(1);
  localparam logic [IB-1:0] X_KY = IB'(INPUT_WIDTH - (KS - 1));
  localparam logic [IB-1:0] X_C  = IB'(plane_stride(INPUT_HEIGHT, INPUT_WIDTH)
                                       - (KS - 1) * INPUT_WIDTH - (KS - 1));
  localparam logic [IB-1:0] P_OX = IB'(STRIDE);
  localparam logic [IB-1:0] P_OY = IB'(STRIDE * INPUT_WIDTH - (OW - 1) * STRIDE);
  localparam logic [WB-1:0] W_ONE   = WB'(1);
  localparam logic [WB-1:0] G_STEP  = WB'(LANES * MAC_LEN);
  localparam logic [OB-1:0] O_ONE   = OB'(1);
  localparam logic [OB-1:0] O_GSTEP = OB'((LANES - 1) * OHOW + 1);

  state_t              state;
  logic [DW-1:0]       drain_cnt;
  logic [IB-1:0]       pix_base, x_step;
  logic [WB-1:0]       g_base;
  logic [OB-1:0]       out_idx;
  logic [LANES*WB-1:0] w_first;
  logic [LANES*OB-1:0] out_first;
  logic kx_inc, ky_inc, c_inc, ox_inc, oy_inc, g_inc, mac_last, layer_last;
  logic kx_wrap, ky_wrap, c_wrap, ox_wrap, oy_wrap, g_wrap;

  assign kx_inc     = (state == S_MAC);
  assign ky_inc     = kx_inc & kx_wrap;
  assign c_inc      = ky_inc & ky_wrap;
  assign mac_last   = c_inc & c_wrap;
  assign ox_inc     = (state == S_WRITE);
  assign oy_inc     = ox_inc & ox_wrap;
  assign g_inc      = oy_inc & oy_wrap;
  assign layer_last = g_inc & g_wrap;

  conv_loop_counter #(.LIMIT(KS))       u_kx (.clk(clk), .rst_n(rst_n), .inc(kx_inc), .wrap(kx_wrap));
  conv_loop_counter #(.LIMIT(KS))       u_ky (.clk(clk), .rst_n(rst_n), .inc(ky_inc), .wrap(ky_wrap));
  conv_loop_counter #(.LIMIT(CHANNELS)) u_c  (.clk(clk), .rst_n(rst_n), .inc(c_inc),  .wrap(c_wrap));
  conv_loop_counter #(.LIMIT(OW))       u_ox (.clk(clk), .rst_n(rst_n), .inc(ox_inc), .wrap(ox_wrap));
  conv_loop_counter #(.LIMIT(OH))       u_oy (.clk(clk), .rst_n(rst_n), .inc(oy_inc), .wrap(oy_wrap));
  conv_loop_counter #(.LIMIT(GROUPS))   u_g  (.clk(clk), .rst_n(rst_n), .inc(g_inc),  .wrap(g_wrap));

  always_comb begin
    w_first   = '0;
    out_first = '0;
    x_step    = ky_inc ? (c_inc ? X_C : X_KY) : X_KX;
    for (int l = 0; l < LANES; l++) begin
      w_first[l*WB +: WB]   = g_base + WB'(l * MAC_LEN);
      out_first[l*OB +: OB] = out_idx + OB'(l * OHOW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      clear       <= 1'b0;
      valid       <= 1'b0;
      write       <= 1'b0;
      x_address   <= '0;
      w_address   <= '0;
      out_address <= '0;
      pix_base    <= '0;
      g_base      <= '0;
      out_idx     <= '0;
      drain_cnt   <= '0;
    end else begin
      done  <= 1'b0;
      clear <= 1'b0;
      write <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          state <= S_CLEAR;
          busy  <= 1'b1;
          clear <= 1'b1;
        end
        S_CLEAR: begin
          state     <= S_MAC;
          valid     <= 1'b1;
          x_address <= pix_base;
          w_address <= w_first;
        end
        S_MAC: if (mac_last) begin
          valid     <= 1'b0;
          x_address <= '0;
          w_address <= '0;
          if (ENGINE_LATENCY == 0) begin
            state       <= S_WRITE;
            write       <= 1'b1;
            out_address <= out_first;
          end else begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end else begin
          x_address <= x_address + x_step;
          for (int l = 0; l < LANES; l++)
            w_address[l*WB +: WB] <= w_address[l*WB +: WB] + W_ONE;
        end
        S_DRAIN: if (drain_cnt == DW'(ENGINE_LATENCY - 1)) begin
          state       <= S_WRITE;
          write       <= 1'b1;
          out_address <= out_first;
        end else begin
          drain_cnt <= drain_cnt + DW'(1);
        end
        // Commit cycle: advance pixel / group bases for the next window.
        S_WRITE: begin
          out_address <= '0;
          if (layer_last) begin
            state    <= S_DONE;
            done     <= 1'b1;
            pix_base <= '0;
            g_base   <= '0;
            out_idx  <= '0;
          end else begin
            state <= S_CLEAR;
            clear <= 1'b1;
            if (g_inc) begin
              pix_base <= '0;
              g_base   <= g_base + G_STEP;
              out_idx  <= out_idx + O_GSTEP;
            end else begin
              pix_base <= pix_base + (oy_inc ? P_OY : P_OX);
              out_idx  <= out_idx + O_ONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_scheduler.sv
// Bench for conv2d_scheduler: per-cycle trace from a loop-nest model, plus an engine model checked against direct convolution.
module tb_conv2d_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
  logic start_d, start_c;
  logic busy_d, done_d, clear_d, valid_d, write_d;
  logic busy_c, done_c, clear_c, valid_c, write_c;
  logic [7:0]  x_d, x_c;
  logic [31:0] w_d, w_c;
  logic [27:0] o_d, o_c;
  logic busy, done, clear, valid, write;
  logic [7:0]  x;
  logic [31:0] w;
  logic [27:0] o;

  typedef struct packed {
    logic busy, done, clear, valid, write;
    logic [7:0]  x;
    logic [31:0] w;
    logic [27:0] o;
  } cyc_t;

  cyc_t exp_q[$];
  int n_run = 0, n_fail = 0;
  int in_mem[256], wt_mem[256], res[128], acc[4];

  always #5 clk = ~clk;

  assign start_d = start & ~sel;
  assign start_c = start & sel;
  assign busy  = sel ? busy_c  : busy_d;
  assign done  = sel ? done_c  : done_d;
  assign clear = sel ? clear_c : clear_d;
  assign valid = sel ? valid_c : valid_d;
  assign write = sel ? write_c : write_d;
  assign x     = sel ? x_c : x_d;
  assign w     = sel ? w_c : w_d;
  assign o     = sel ? o_c : o_d;

  conv2d_scheduler u_dflt (
    .clk(clk), .rst_n(rst_n), .start(start_d), .busy(busy_d), .done(done_d),
    .clear(clear_d), .valid(valid_d), .x_address(x_d), .w_address(w_d),
    .out_address(o_d), .write(write_d)
  );

  conv2d_scheduler #(
    .KERNEL_SIZE(3), .KERNELS(8), .LANES(4), .STRIDE(2), .INPUT_WIDTH(7),
    .INPUT_HEIGHT(7), .CHANNELS(3), .ENGINE_LATENCY(2)
  ) u_cfg (
    .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
    .clear(clear_c), .valid(valid_c), .x_address(x_c), .w_address(w_c),
    .out_address(o_c), .write(write_c)
  );

  // Behavioural conv engine driven by the selected scheduler.
  always @(negedge clk) begin
    if (sel) begin
      for (int l = 0; l < 4; l++) begin
        if (clear) acc[l] <= 0;
        else if (valid) acc[l] <= acc[l] + in_mem[x] * wt_mem[w[l*8 +: 8]];
        if (write) res[o[l*7 +: 7]] <= acc[l];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_run++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ctl"}, 64'({busy, done, clear, valid, write}), 64'd0);
    chk({tag, ".x"}, 64'(x), 64'd0);
    chk({tag, ".w"}, 64'(w), 64'd0);
    chk({tag, ".o"}, 64'(o), 64'd0);
  endtask

  task automatic build(input int ks, input int kern, input int ln, input int st,
                       input int wd, input int ht, input int ch, input int el);
    int ow, oh, ml;
    cyc_t e;
    ow = (wd - ks) / st + 1;
    oh = (ht - ks) / st + 1;
    ml = ks * ks * ch;
    exp_q.delete();
    for (int g = 0; g < kern / ln; g++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          e = '0; e.busy = 1'b1; e.clear = 1'b1; exp_q.push_back(e);
          for (int c = 0; c < ch; c++)
            for (int ky = 0; ky < ks; ky++)
              for (int kx = 0; kx < ks; kx++) begin
                e = '0; e.busy = 1'b1; e.valid = 1'b1;
                e.x = 8'(c * ht * wd + (oy * st + ky) * wd + ox * st + kx);
                for (int l = 0; l < ln; l++)
                  e.w[l*8 +: 8] = 8'((g * ln + l) * ml + c * ks * ks + ky * ks + kx);
                exp_q.push_back(e);
              end
          for (int d = 0; d < el; d++) begin
            e = '0; e.busy = 1'b1; exp_q.push_back(e);
          end
          e = '0; e.busy = 1'b1; e.write = 1'b1;
          for (int l = 0; l < ln; l++)
            e.o[l*7 +: 7] = 7'((g * ln + l) * oh * ow + oy * ow + ox);
          exp_q.push_back(e);
        end
    e = '0; e.busy = 1'b1; e.done = 1'b1; exp_q.push_back(e);
    e = '0; exp_q.push_back(e);
  endtask

  // Entry i of the trace is cycle i+1 after the edge that samples start.
  task automatic run_trace(input string tag, input bit hold, input int limit);
    int n;
    n = (limit < exp_q.size()) ? limit : exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s.ctl@%0d", tag, i + 1), 64'({busy, done, clear, valid, write}),
          64'({exp_q[i].busy, exp_q[i].done, exp_q[i].clear, exp_q[i].valid, exp_q[i].write}));
      chk($sformatf("%s.x@%0d", tag, i + 1), 64'(x), 64'(exp_q[i].x));
      chk($sformatf("%s.w@%0d", tag, i + 1), 64'(w), 64'(exp_q[i].w));
      chk($sformatf("%s.o@%0d", tag, i + 1), 64'(o), 64'(exp_q[i].o));
      if (!hold) start = 1'b0;
    end
  endtask

  initial begin
    int gap, sum;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1 check_zero("rst_dflt");
    sel = 1'b1; #1 check_zero("rst_cfg");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    build(3, 4, 4, 1, 5, 5, 3, 1);
    gap = $urandom_range(1, 4);
    repeat (gap) @(negedge clk);
    start = 1'b1;
    run_trace("pulse", 1'b0, 1 << 30);

    start = 1'b1;
    run_trace("held1", 1'b1, 1 << 30);
    run_trace("held2", 1'b0, 1 << 30);
    repeat (2) begin
      @(negedge clk);
      check_zero("idle_after");
    end

    gap = $urandom_range(1, 4);
    repeat (gap) @(negedge clk);
    start = 1'b1;
    run_trace("prerst", 1'b0, 100);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    check_zero("in_rst");
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    run_trace("postrst", 1'b0, 1 << 30);

    sel = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_mem[i] = int'($urandom_range(0, 255));
      wt_mem[i] = int'($urandom_range(0, 255));
    end
    for (int i = 0; i < 128; i++) res[i] = -1;
    build(3, 8, 4, 2, 7, 7, 3, 2);
    @(negedge clk);
    start = 1'b1;
    run_trace("cfg", 1'b0, 1 << 30);
    @(negedge clk);
    for (int k = 0; k < 8; k++)
      for (int oy = 0; oy < 3; oy++)
        for (int ox = 0; ox < 3; ox++) begin
          sum = 0;
          for (int c = 0; c < 3; c++)
            for (int ky = 0; ky < 3; ky++)
              for (int kx = 0; kx < 3; kx++)
                sum += in_mem[c*49 + (oy*2 + ky)*7 + ox*2 + kx] * wt_mem[k*27 + c*9 + ky*3 + kx];
          chk($sformatf("result[%0d]", k*9 + oy*3 + ox), 64'(res[k*9 + oy*3 + ox]), 64'(sum));
        end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
